// File: rtl/mem_stage_if.sv
// MEM-stage pipeline bus: EX/MEM payload in; stall, branch decision and MEM/WB payload out.
interface mem_stage_if;
  logic         pwrite4;
  logic [107:0] ex_mem_content;
  logic         stall;
  logic         pc_src;
  logic [31:0]  branch_target_out;
  logic [70:0]  mem_wb_content;

  modport master (
    output pwrite4, ex_mem_content,
    input  stall, pc_src, branch_target_out, mem_wb_content
  );

  modport slave (
    input  pwrite4, ex_mem_content,
    output stall, pc_src, branch_target_out, mem_wb_content
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS MEM stage: multi-cycle load/store on a word-addressed data memory,
// branch resolution and the MEM/WB pipeline register.
module mem_stage #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic      clk,
  input  logic      rst,
  mem_stage_if.slave bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

  logic [4:0]  dest;
  logic [31:0] read_rt;
  logic [31:0] alu_output;
  logic        zero;
  logic [31:0] branch_target;
  logic        ctl_branch, ctl_mem_read, ctl_mem_write, ctl_reg_write, ctl_mem_to_reg;
  logic        unused_ctl;

  assign dest           = bus.ex_mem_content[107:103];
  assign read_rt        = bus.ex_mem_content[102:71];
  assign alu_output     = bus.ex_mem_content[70:39];
  assign zero           = bus.ex_mem_content[38];
  assign branch_target  = bus.ex_mem_content[37:6];
  assign ctl_branch     = bus.ex_mem_content[0];
  assign ctl_mem_read   = bus.ex_mem_content[1];
  assign ctl_mem_write  = bus.ex_mem_content[2];
  assign ctl_reg_write  = bus.ex_mem_content[3];
  assign ctl_mem_to_reg = bus.ex_mem_content[4];
  assign unused_ctl     = bus.ex_mem_content[5];

  logic [CW-1:0]         cnt, cnt_next;
  logic                  memop, at_last, complete;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           read_data;
  logic [31:0]           mem [0:DEPTH-1];

  assign memop    = ctl_mem_read | ctl_mem_write;
  assign at_last  = (cnt == LAST);
  assign complete = memop && at_last;
  // Byte offset and high address bits dropped: addresses wrap at the memory depth.
  assign idx       = alu_output[DEPTH_LOG2+1:2];
  assign read_data = mem[idx];

  assign bus.stall             = memop && !at_last;
  assign bus.pc_src            = ctl_branch & zero;
  assign bus.branch_target_out = branch_target;

  // Access sequencer: IDLE when cnt==0, WAIT otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_next;
  end

  always_comb begin
    cnt_next = '0;
    if (memop && !at_last) cnt_next = cnt + CW'(1);
  end

  // Store commits only on the completing edge; memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (complete && ctl_mem_write) mem[idx] <= read_rt;
  end

  // A stalled instruction emits a bubble so it reaches WB exactly once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         bus.mem_wb_content <= '0;
    else if (!bus.pwrite4 || bus.stall) bus.mem_wb_content <= '0;
    else bus.mem_wb_content <= {ctl_reg_write, ctl_mem_to_reg, read_data, alu_output, dest};
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: LATENCY=2 instance for main behaviour,
// LATENCY=4 instance for reset in the middle of an access.
module tb_mem_stage;

  localparam logic [5:0] C_BR = 6'd1, C_MR = 6'd2, C_MW = 6'd4, C_RW = 6'd8, C_M2R = 6'd16;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mem_stage_if bus_a ();
  mem_stage_if bus_b ();

  mem_stage #(.DEPTH_LOG2(8), .LATENCY(2)) u_dut  (.clk(clk), .rst(rst_a), .bus(bus_a));
  mem_stage #(.DEPTH_LOG2(8), .LATENCY(4)) u_dut4 (.clk(clk), .rst(rst_b), .bus(bus_b));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [107:0] mk(input logic [4:0] d, input logic [31:0] rt,
                                      input logic [31:0] alu, input logic z,
                                      input logic [31:0] bt, input logic [5:0] c);
    return {d, rt, alu, z, bt, c};
  endfunction

  function automatic logic [70:0] wb(input logic rw, input logic m2r, input logic [31:0] rd,
                                     input logic [31:0] alu, input logic [4:0] d);
    return {rw, m2r, rd, alu, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.pwrite4 = 1'b1; bus_a.ex_mem_content = '0;
    bus_b.pwrite4 = 1'b1; bus_b.ex_mem_content = '0;
    tick(); tick();
    check("rst_mem_wb", bus_a.mem_wb_content, 0);
    check("rst_stall",  bus_a.stall, 0);
    check("rst_pc_src", bus_a.pc_src, 0);
    rst_a = 1'b0; rst_b = 1'b0;

    // Seed word 0x8D so ALU pass-through read_data is known.
    bus_a.ex_mem_content = mk(5'd0, 32'h5A5A5A5A, 32'h1234, 1'b0, 32'h0, C_MW);
    #1 check("seed_stall", bus_a.stall, 1);
    tick();
    check("seed_bubble", bus_a.mem_wb_content, 0);
    check("seed_stall_drop", bus_a.stall, 0);
    tick();

    bus_a.ex_mem_content = mk(5'd3, 32'h0, 32'h1234, 1'b0, 32'h0, C_RW);
    #1 check("alu_stall", bus_a.stall, 0);
    tick();
    check("alu_pass", bus_a.mem_wb_content, wb(1'b1, 1'b0, 32'h5A5A5A5A, 32'h1234, 5'd3));
    for (int i = 0; i < 4; i++) begin
      bus_a.ex_mem_content = mk(5'(4 + i), 32'h0, 32'h1234 + 32'(i), 1'b0, 32'h0, C_RW);
      tick();
      check($sformatf("alu_b2b%0d", i), bus_a.mem_wb_content,
            wb(1'b1, 1'b0, 32'h5A5A5A5A, 32'h1234 + 32'(i), 5'(4 + i)));
    end

    bus_a.ex_mem_content = mk(5'd0, 32'hDEADBEEF, 32'h10, 1'b0, 32'h0, C_MW);
    #1 check("st_stall", bus_a.stall, 1);
    tick();
    check("st_bubble", bus_a.mem_wb_content, 0);
    check("st_stall_drop", bus_a.stall, 0);
    tick();
    bus_a.ex_mem_content = mk(5'd8, 32'h0, 32'h10, 1'b0, 32'h0, C_MR | C_RW | C_M2R);
    #1 check("ld_stall", bus_a.stall, 1);
    tick();
    check("ld_bubble", bus_a.mem_wb_content, 0);
    tick();
    check("ld_data", bus_a.mem_wb_content, wb(1'b1, 1'b1, 32'hDEADBEEF, 32'h10, 5'd8));

    bus_a.ex_mem_content = mk(5'd0, 32'h0, 32'h0, 1'b1, 32'h400, C_BR);
    #1;
    check("br_taken",  bus_a.pc_src, 1);
    check("br_target", bus_a.branch_target_out, 32'h400);
    check("br_stall",  bus_a.stall, 0);
    bus_a.ex_mem_content = mk(5'd0, 32'h0, 32'h0, 1'b0, 32'h400, C_BR);
    #1 check("br_not_taken", bus_a.pc_src, 0);
    tick();

    // 0x400 wraps to word 0 with 256-word memory.
    bus_a.ex_mem_content = mk(5'd0, 32'hCAFEF00D, 32'h400, 1'b0, 32'h0, C_MW);
    tick(); tick();
    bus_a.ex_mem_content = mk(5'd9, 32'h0, 32'h0, 1'b0, 32'h0, C_MR | C_RW | C_M2R);
    tick(); tick();
    check("wrap_ld", bus_a.mem_wb_content, wb(1'b1, 1'b1, 32'hCAFEF00D, 32'h0, 5'd9));
    bus_a.pwrite4 = 1'b0;
    tick();
    check("bubble_stall", bus_a.mem_wb_content, 0);
    tick();
    check("bubble_pw4", bus_a.mem_wb_content, 0);
    bus_a.pwrite4 = 1'b1;
    bus_a.ex_mem_content = '0;

    // LATENCY=4: preload, then abort a store with reset.
    bus_b.ex_mem_content = mk(5'd0, 32'h11111111, 32'h20, 1'b0, 32'h0, C_MW);
    tick(); tick();
    check("l4_stall_3rd", bus_b.stall, 1);
    tick();
    check("l4_stall_done", bus_b.stall, 0);
    tick();
    bus_b.ex_mem_content = mk(5'd0, 32'h22222222, 32'h20, 1'b0, 32'h0, C_MW);
    tick();
    check("l4_cnt_wait", u_dut4.cnt, 1);
    rst_b = 1'b1;
    #1 check("l4_rst_cnt", u_dut4.cnt, 0);
    bus_b.ex_mem_content = '0;
    #1 check("l4_rst_stall", bus_b.stall, 0);
    check("l4_rst_wb", bus_b.mem_wb_content, 0);
    tick();
    rst_b = 1'b0;
    bus_b.ex_mem_content = mk(5'd10, 32'h0, 32'h20, 1'b0, 32'h0, C_MR | C_RW | C_M2R);
    tick(); tick(); tick();
    check("l4_ld_pending", bus_b.mem_wb_content, 0);
    tick();
    check("l4_ld_old", bus_b.mem_wb_content, wb(1'b1, 1'b1, 32'h11111111, 32'h20, 5'd10));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access (MEM) stage of the five-stage MIPS pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes that register's packed content bus. It performs loads and stores against an internal word-addressed data memory with a configurable multi-cycle access latency, stalling upstream while an access is in flight. It resolves the branch decision and drives the packed MEM/WB pipeline register.

## Interface
- DEPTH_LOG2, 8: log2 of data-memory depth in 32-bit words.
- LATENCY, 2: cycles per load/store, ≥1.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pwrite4  in  1  MEM/WB write enable; low loads a bubble (all zeros).
- ex_mem_content  in  108  packed EX/MEM bus:
  - [107:103] destination_reg
  - [102:71] read_Rt
  - [70:39] ALU_Output
  - [38] zero
  - [37:6] branch_target
  - [5:0] control_signals: [0] Branch, [1] MemRead, [2] MemWrite, [3] RegWrite, [4] MemtoReg, [5] reserved, ignored.
- stall  out  1  upstream must hold PC, IF/ID, ID/EX and EX/MEM this cycle.
- pc_src  out  1  take branch.
- branch_target_out  out  32  branch target to PC mux.
- mem_wb_content  out  71  packed MEM/WB bus:
  - [70] RegWrite
  - [69] MemtoReg
  - [68:37] read_data
  - [36:5] ALU_Output
  - [4:0] destination_reg

## Operation
- memop = MemRead | MemWrite.
- Word index = ALU_Output[DEPTH_LOG2+1:2]. Bits [1:0] are ignored, and upper bits are ignored, so addresses wrap modulo the memory depth.
- Access sequencer uses a counter cnt, width ceil(log2(LATENCY)), minimum 1 bit, reset 0.
  - IDLE: cnt==0.
  - WAIT: cnt>0.
  - Rising edge with memop && cnt!=LATENCY-1: cnt<=cnt+1.
  - Any other rising edge: cnt<=0. This returns the sequencer to IDLE.
- Complete edge = rising edge with memop && cnt==LATENCY-1. With LATENCY=1, every memop edge is a complete edge.
- stall = memop && cnt!=LATENCY-1. This is combinational from ex_mem_content and cnt, and is never asserted when LATENCY=1.
- Store: on the complete edge, mem[index] <= read_Rt. No write happens on any other edge.
- Load: read_data = mem[index], read combinationally. It is captured into mem_wb_content on the complete edge.
- MemRead and MemWrite both set: the write occurs, and read_data carries the pre-write value.
- Non-memop instructions pass through in one cycle with no stall. read_data is captured as the current mem[index] value and is unused downstream because MemtoReg=0.
- pc_src = Branch & zero, combinational. branch_target_out = branch_target, combinational. Branch instructions never stall.
- mem_wb_content update on each rising edge:
  - pwrite4==0: load all zeros (bubble).
  - else stall==1: load all zeros. The stalled instruction must not be duplicated downstream.
  - else: load {RegWrite, MemtoReg, read_data, ALU_Output, destination_reg}.
- Reset (rst high, asynchronous):
  - cnt=0, mem_wb_content=0.
  - With ex_mem_content=0, stall=0 and pc_src=0.
  - Data-memory contents are not reset; they are X until written.
- Reset mid-access (rst during WAIT): cnt clears immediately. The pending store is dropped, memory is unchanged, and no MEM/WB entry is produced.
- Upstream contract: ex_mem_content is stable for every cycle in which stall=1.

## Timing
- Non-memop: mem_wb_content is valid 1 edge after ex_mem_content is presented.
- Memop: stall is high for LATENCY-1 cycles, beginning in the cycle the instruction is presented. The store write and the MEM/WB capture occur on edge LATENCY. mem_wb_content is valid after that edge.
- Back-to-back memops: after a complete edge, cnt=0, so the next memop starts its own LATENCY-cycle access immediately. There are no dead cycles.
- A load following a store to the same index on the next access sees the stored data.
- pc_src, branch_target_out and stall are zero-latency combinational outputs.

## Test plan
- **Reset:** rst=1 for 2 cycles with ex_mem_content=0 → mem_wb_content=0, stall=0, pc_src=0. Release rst, feed a non-memop → output is valid on the next edge.
- **Store/load, LATENCY=2:**
  - Store 0xDEADBEEF to address 0x10 → stall=1 for exactly 1 cycle, and mem_wb_content=0 during the stall.
  - Then load address 0x10 with RegWrite=1, MemtoReg=1, dest=8 → after 2 edges, mem_wb_content = {1, 1, 0xDEADBEEF, 0x00000010, 8}.
- **ALU pass-through:** RegWrite=1, MemtoReg=0, ALU_Output=0x1234, dest=3 → stall=0, and the next edge gives mem_wb_content={1, 0, X-free read_data, 0x1234, 3}. A back-to-back sequence of 4 such instructions produces 4 consecutive outputs.
- **Branch:**
  - Branch=1, zero=1, branch_target=0x400 → pc_src=1 and branch_target_out=0x400 in the same cycle, stall=0.
  - Set zero=0 → pc_src=0.
- **Reset mid-access, LATENCY=4:**
  - Preload 0x11111111 at address 0x20.
  - Store 0x22222222 to 0x20 and assert rst in the 2nd stall cycle → cnt=0 and stall drops when ex_mem_content is cleared.
  - A subsequent load of 0x20 returns 0x11111111.
- **Wrap and bubble, DEPTH_LOG2=8:**
  - Store 0xCAFEF00D to address 0x400 → a load from 0x000 returns 0xCAFEF00D.
  - Repeat the load with pwrite4=0 → mem_wb_content=0.
